// File: rtl/key_matrix_pkg.sv
// Shared types and geometry for the 8x8 key matrix scanner.
// Bit layout matches the display path: line 1 = [63:56] ... line 8 = [7:0].
package key_matrix_pkg;

  localparam int LINE_W    = 8;
  localparam int NUM_LINES = 8;
  localparam int MATRIX_W  = LINE_W * NUM_LINES;
  localparam int IDX_W     = 6;
  localparam int COL_W     = 3;
  localparam int TOP_BIT   = MATRIX_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_UPDATE = 3'd4
  } scan_state_e;

  function automatic int lineHi(input logic [COL_W-1:0] line);
    return TOP_BIT - LINE_W * int'(line);
  endfunction

endpackage

// File: rtl/key_matrix_scanner_if.sv
// Press/release event handshake between scanner and consumer.
// The scanner is master; eventAck comes back from the consumer.
interface key_matrix_scanner_if;
  import key_matrix_pkg::*;

  logic             eventValid;
  logic [IDX_W-1:0] eventCode;
  logic             eventPressed;
  logic             eventAck;

  modport master (
    output eventValid,
    output eventCode,
    output eventPressed,
    input  eventAck
  );

  modport slave (
    input  eventValid,
    input  eventCode,
    input  eventPressed,
    output eventAck
  );

endinterface

// File: rtl/matrix_priority_enc.sv
// Highest-set-bit encoder over the 64-bit key mask.
// Ascending loop so the last (highest) set index wins.
module matrix_priority_enc
  import key_matrix_pkg::*;
(
  input  logic [MATRIX_W-1:0] mask,
  output logic [IDX_W-1:0]    idx,
  output logic                any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < MATRIX_W; i++) begin
      if (mask[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_matrix_scanner.sv
// Column-strobed 8x8 key matrix scanner with frame debounce
// and a one-at-a-time press/release event queue.
module key_matrix_scanner
  import key_matrix_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scanPulseIn,
  input  logic [LINE_W-1:0]   rowIn,
  output wire  [LINE_W-1:0]   colOut,
  output logic [MATRIX_W-1:0] matrixOut,
  output logic                scanBusy,
  output logic                frameDone,
  key_matrix_scanner_if.master eventBus
);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] DRIVE  = ST_DRIVE;
  localparam logic [2:0] SETTLE = ST_SETTLE;
  localparam logic [2:0] SAMPLE = ST_SAMPLE;
  localparam logic [2:0] UPDATE = ST_UPDATE;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] DEB         = 4'(DEBOUNCE_SCANS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_LINES - 1);

  logic [2:0]          state;
  logic [COL_W-1:0]    col;
  logic [7:0]          settleCnt;
  logic [LINE_W-1:0]   rowMeta;
  logic [LINE_W-1:0]   rowSyncQ;
  logic [LINE_W-1:0]   rowSync;
  logic [MATRIX_W-1:0] raw;
  logic [MATRIX_W-1:0] prevRaw;
  logic [3:0]          count;
  logic [3:0]          countNext;
  logic [MATRIX_W-1:0] matrixNext;
  logic [MATRIX_W-1:0] delta;
  logic [MATRIX_W-1:0] ackBit;
  logic [MATRIX_W-1:0] pendingMask;
  logic [MATRIX_W-1:0] pendingNext;
  logic [IDX_W-1:0]    encIdx;
  logic                encAny;
  logic                colLow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rowMeta  <= '1;
      rowSyncQ <= '1;
    end else begin
      rowMeta  <= rowIn;
      rowSyncQ <= rowMeta;
    end
  end

  assign rowSync  = ~rowSyncQ;
  assign scanBusy = (state != IDLE);
  assign colLow   = (state == DRIVE) ||
                    (state == SETTLE) ||
                    (state == SAMPLE);

  // Open-drain style: only the active column is pulled low.
  for (genvar g = 0; g < LINE_W; g++) begin : gCol
    assign colOut[g] =
      (colLow && col == COL_W'(LINE_W - 1 - g)) ? 1'b0 : 1'bz;
  end

  always_comb begin
    if (raw == prevRaw)
      countNext = (count >= DEB) ? DEB : count + 4'd1;
    else
      countNext = 4'd1;
    delta      = '0;
    matrixNext = matrixOut;
    if (state == UPDATE && countNext == DEB &&
        raw != matrixOut) begin
      delta      = raw ^ matrixOut;
      matrixNext = raw;
    end
    ackBit = '0;
    if (eventBus.eventValid && eventBus.eventAck)
      ackBit[eventBus.eventCode] = 1'b1;
    pendingNext = (pendingMask & ~ackBit) ^ delta;
  end

  matrix_priority_enc uEnc (
    .mask (pendingNext),
    .idx  (encIdx),
    .any  (encAny)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      col       <= '0;
      settleCnt <= '0;
      raw       <= '0;
      prevRaw   <= '0;
      count     <= '0;
      matrixOut <= '0;
      frameDone <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      unique case (state)
        IDLE: begin
          if (scanPulseIn) begin
            col   <= '0;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          settleCnt <= SETTLE_LOAD;
          state     <= SETTLE;
        end
        SETTLE: begin
          if (settleCnt == '0)
            state <= SAMPLE;
          else
            settleCnt <= settleCnt - 8'd1;
        end
        SAMPLE: begin
          raw[lineHi(col) -: LINE_W] <= rowSync;
          if (col == COL_LAST) begin
            state <= UPDATE;
          end else begin
            col   <= col + 1'b1;
            state <= DRIVE;
          end
        end
        UPDATE: begin
          count     <= countNext;
          prevRaw   <= raw;
          matrixOut <= matrixNext;
          frameDone <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pendingMask           <= '0;
      eventBus.eventValid   <= 1'b0;
      eventBus.eventCode    <= '0;
      eventBus.eventPressed <= 1'b0;
    end else begin
      pendingMask           <= pendingNext;
      eventBus.eventValid   <= encAny;
      eventBus.eventCode    <= encIdx;
      eventBus.eventPressed <= matrixNext[encIdx];
    end
  end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Randomized and directed bench for key_matrix_scanner against
// a frame-level key/debounce/event reference model.
module tb_key_matrix_scanner;
  import key_matrix_pkg::*;

  localparam int SET = 4;
  localparam int DEB = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scanPulseIn = 1'b0;
  logic [7:0]  rowIn;
  wire  [7:0]  colW;
  logic [63:0] matrixOut;
  logic        scanBusy;
  logic        frameDone;

  key_matrix_scanner_if evIf();

  key_matrix_scanner #(
    .SETTLE_CYCLES  (SET),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scanPulseIn (scanPulseIn),
    .rowIn       (rowIn),
    .colOut      (colW),
    .matrixOut   (matrixOut),
    .scanBusy    (scanBusy),
    .frameDone   (frameDone),
    .eventBus    (evIf)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < 8; g++) begin : gPull
    pullup (colW[g]);
  end

  int total = 0;
  int bad   = 0;

  logic [63:0] keys = '0;
  logic [63:0] mMatrix = '0;
  logic [63:0] mPend = '0;
  logic [63:0] hist[$];

  // Physical matrix: key at (col c, row r) is bit 56-8c+r.
  always_comb begin
    rowIn = 8'hFF;
    for (int c = 0; c < 8; c++)
      if (colW[7-c] == 1'b0)
        for (int r = 0; r < 8; r++)
          if (keys[56-8*c+r]) rowIn[r] = 1'b0;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int topIdx(input logic [63:0] m);
    for (int i = 63; i >= 0; i--)
      if (m[i]) return i;
    return -1;
  endfunction

  task automatic modelFrame(input logic [63:0] f);
    bit same;
    hist.push_back(f);
    if (hist.size() > DEB) hist.delete(0);
    if (hist.size() == DEB) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != f) same = 1'b0;
      if (same && f != mMatrix) begin
        mPend   = mPend ^ (f ^ mMatrix);
        mMatrix = f;
      end
    end
  endtask

  task automatic chkEvt(input string tag);
    int t;
    t = topIdx(mPend);
    chk({tag, ".valid"}, 64'(evIf.eventValid), 64'(t >= 0));
    if (t >= 0) begin
      chk({tag, ".code"}, 64'(evIf.eventCode), 64'(t));
      chk({tag, ".pressed"}, 64'(evIf.eventPressed),
          64'(mMatrix[t]));
    end
  endtask

  task automatic doAck(input string tag);
    int t;
    t = topIdx(mPend);
    evIf.eventAck = 1'b1;
    @(negedge clk);
    evIf.eventAck = 1'b0;
    if (t >= 0) mPend[t] = 1'b0;
    chkEvt(tag);
  endtask

  task automatic resetDut();
    rst = 1'b0;
    scanPulseIn = 1'b0;
    evIf.eventAck = 1'b0;
    keys = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    mMatrix = '0;
    mPend = '0;
    hist.delete();
    @(negedge clk);
  endtask

  task automatic doScan(input string tag,
                        input logic [63:0] k,
                        input int ackAt);
    int cyc, lowCyc, busyCyc, multi, nz, lastLow, lowBit, t;
    logic [31:0] seq;
    bit done;
    cyc = 0; lowCyc = 0; busyCyc = 0; multi = 0;
    lastLow = -1; seq = '0; done = 1'b0;
    keys = k;
    scanPulseIn = 1'b1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      scanPulseIn = 1'b0;
      if (evIf.eventAck) begin
        evIf.eventAck = 1'b0;
      end else if (cyc == ackAt) begin
        t = topIdx(mPend);
        if (t >= 0) begin
          evIf.eventAck = 1'b1;
          mPend[t] = 1'b0;
        end
      end
      nz = 0; lowBit = -1;
      for (int b = 0; b < 8; b++)
        if (colW[b] == 1'b0) begin nz++; lowBit = b; end
      if (nz > 1) multi++;
      if (nz == 1) begin
        lowCyc++;
        if (lowBit != lastLow) begin
          seq = {seq[27:0], 4'(lowBit)};
          lastLow = lowBit;
        end
      end
      if (scanBusy) busyCyc++;
      if (frameDone) done = 1'b1;
    end
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".cycles"}, 64'(cyc), 64'(8 * (SET + 2) + 2));
    chk({tag, ".busy"}, 64'(busyCyc), 64'(8 * (SET + 2) + 1));
    chk({tag, ".lowCyc"}, 64'(lowCyc), 64'(8 * (SET + 2)));
    chk({tag, ".overlap"}, 64'(multi), 64'd0);
    chk({tag, ".order"}, 64'(seq), 64'h7654_3210);
    modelFrame(k);
    chk({tag, ".matrix"}, matrixOut, mMatrix);
    chkEvt(tag);
    if (evIf.eventAck) begin
      @(negedge clk);
      evIf.eventAck = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] k;
    int hold, n;
    bit hit;
    evIf.eventAck = 1'b0;
    resetDut();

    chk("rst.col", 64'(colW), 64'hFF);
    chk("rst.matrix", matrixOut, 64'd0);
    chk("rst.busy", 64'(scanBusy), 64'd0);
    chk("rst.done", 64'(frameDone), 64'd0);
    chk("rst.valid", 64'(evIf.eventValid), 64'd0);
    chk("rst.code", 64'(evIf.eventCode), 64'd0);
    chk("rst.pressed", 64'(evIf.eventPressed), 64'd0);

    doScan("idle", 64'd0, 0);
    @(negedge clk);
    chk("idle.donePulse", 64'(frameDone), 64'd0);

    for (int s = 0; s < 3; s++) begin
      doScan("k34", 64'd1 << 34, 0);
      chk("k34.bit", 64'(matrixOut[34]), 64'(s == 2));
    end
    chk("k34.code", 64'(evIf.eventCode), 64'd34);
    doAck("k34.ack");
    chk("k34.cleared", 64'(evIf.eventValid), 64'd0);

    resetDut();
    for (int s = 0; s < 6; s++) begin
      doScan("bounce", (s == 2) ? 64'd0 : 64'd1 << 34, 0);
      chk("bounce.bit", 64'(matrixOut[34]), 64'(s == 5));
    end

    resetDut();
    for (int s = 0; s < 3; s++)
      doScan("k0k63", 64'h8000_0000_0000_0001, 0);
    repeat (5) @(negedge clk);
    chk("k0k63.hold", 64'(evIf.eventCode), 64'd63);
    doAck("k0k63.ack1");
    chk("k0k63.next", 64'(evIf.eventCode), 64'd0);
    doAck("k0k63.ack2");

    resetDut();
    for (int s = 0; s < 3; s++) doScan("k10p", 64'd1 << 10, 0);
    chk("k10.pend", 64'(evIf.eventValid), 64'd1);
    for (int s = 0; s < 3; s++) doScan("k10r", 64'd0, 0);
    chk("k10.cancel", 64'(evIf.eventValid), 64'd0);

    resetDut();
    for (int s = 0; s < 3; s++) doScan("pre", 64'd1 << 5, 0);
    scanPulseIn = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      scanPulseIn = 1'b0;
      if (colW[2] == 1'b0) hit = 1'b1;
    end
    chk("mid.reach", 64'(hit), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid.col", 64'(colW), 64'hFF);
    chk("mid.matrix", matrixOut, 64'd0);
    chk("mid.busy", 64'(scanBusy), 64'd0);
    chk("mid.valid", 64'(evIf.eventValid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    mMatrix = '0;
    mPend = '0;
    hist.delete();
    @(negedge clk);
    doScan("mid.rescan", 64'd1 << 5, 0);

    resetDut();
    for (int it = 0; it < 30; it++) begin
      k = '0;
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) k[$urandom_range(0, 63)] = 1'b1;
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++)
        doScan("rnd", k,
               ($urandom_range(0, 1) == 1) ? $urandom_range(1, 49) : 0);
      if ($urandom_range(0, 2) == 0) doAck("rnd.ack");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_matrix_scanner.md
# key_matrix_scanner

Input-side counterpart of the LED matrix row/column driver: scans an 8x8 switch/keypad matrix by driving one column line low at a time and sampling the eight row lines. It produces a debounced 64-bit key-state image in the same bit layout the display path consumes (line 1 = [63:56] … line 8 = [7:0]) and a one-event-at-a-time press/release queue with a valid/ack handshake. It sits between the board-level matrix pins and the game/control logic, and is paced by the same kind of time pulse as the display scan.

## Interface
- SETTLE_CYCLES, 4: cycles a column is held before sampling; legal range 2..255.
- DEBOUNCE_SCANS, 3: consecutive identical raw frames required before matrixOut updates; legal range 1..15.
- clk  in  1  system clock.
- rst  in  1  one clock; reset is asynchronous and active-low.
- scanPulseIn  in  1  one-cycle request to start a full 8-column scan.
- rowIn  in  8  row sense lines, externally pulled up; 0 = key closed; asynchronous to clk.
- colOut  out  8  column drive: the active column is 0, all others z.
- matrixOut  out  64  debounced key state; 1 = pressed.
- scanBusy  out  1  high from scan acceptance through UPDATE.
- frameDone  out  1  one-cycle pulse in the cycle after UPDATE.
- eventValid  out  1  a press/release event is pending.
- eventCode  out  6  bit index (0..63) of the key in matrixOut.
- eventPressed  out  1  1 = press, 0 = release.
- eventAck  in  1  consumer accepts the current event.

## Operation
- rowIn passes through a 2-flop synchronizer; the inverted synchronized value is rowSync.
- States: IDLE, DRIVE, SETTLE, SAMPLE, UPDATE.
- IDLE: colOut all z. On scanPulseIn go to DRIVE with col=0. scanPulseIn outside IDLE is ignored and is not queued.
- DRIVE: colOut[7-col]=0, others z; load the settle counter; go to SETTLE.
- SETTLE: hold the drive for SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: raw[63-8*col -: 8] <= rowSync. If col==7 go to UPDATE; otherwise col++ and go to DRIVE.
- UPDATE: colOut all z.
  - If raw==prevRaw, count = min(count+1, DEBOUNCE_SCANS); otherwise count = 1.
  - prevRaw <= raw.
  - If the new count==DEBOUNCE_SCANS and raw!=matrixOut: delta = raw^matrixOut and matrixOut <= raw.
  - Go to IDLE.
- Event queue: 64-bit pendingMask.
  - next pendingMask = (pendingMask & ~ackBit) ^ delta, where ackBit = onehot(eventCode) when eventValid&&eventAck, else 0.
  - A key that presses and then releases before being reported cancels out.
  - eventValid and eventCode are registered from the next pendingMask: highest set index wins.
  - eventPressed = matrixOut[eventCode] using the post-update value.
  - eventAck while eventValid=0 is ignored.

## Timing
- Reset values:
  - colOut = all z; matrixOut, raw, prevRaw, pendingMask = 0; count = 0; state IDLE.
  - scanBusy, frameDone, eventValid, eventPressed = 0; eventCode = 0.
- Reset mid-scan releases colOut to z immediately (asynchronous) and discards the partial frame.
- Per column: 1 + SETTLE_CYCLES + 1 cycles. Full scan: 8*(SETTLE_CYCLES+2)+1 cycles; 49 at the defaults.
- The next column drives in the cycle after SAMPLE; two columns are never low at the same time.
- A stable press first seen in frame N appears in matrixOut at the UPDATE of frame N+DEBOUNCE_SCANS-1.
- eventValid rises 1 cycle after the UPDATE that sets pendingMask.
- After an ack, the next event is presented 1 cycle later; eventValid drops if the queue is empty.
- An ack coinciding with UPDATE applies both in the same cycle, per the equation above.

## Structure
- Shared package key_matrix_pkg:
  - state enum;
  - LINE_W=8, NUM_LINES=8, MATRIX_W=64;
  - line-slice index helper constants.
- One sub-module: matrix_priority_enc (64-bit mask in; 6-bit highest set index and any-set out; combinational).

## Test plan
- Reset, then scanPulseIn with rowIn=8'hFF: frameDone pulses at cycle 50, matrixOut=0, eventValid stays 0, colOut steps 8'h7F-pattern (one 0, rest z) from bit 7 down to bit 0.
- Hold rowIn[2]=0 only while colOut[4]=0 (col 3), for 3 scans: matrixOut[34]=1 after scan 3; eventValid=1, eventCode=34, eventPressed=1; ack clears eventValid.
- Key 34 closed for scans 1–2, open on scan 3, closed on scans 4–6: no update until scan 6.
- Keys 0 and 63 pressed together and debounced: events are 63 then 0, one per ack; no ack leaves eventCode=63 held.
- Press key 10, then release it before acking: after release debounces, pendingMask bit 10 clears and eventValid=0 with no ack issued.
- Assert rst low mid-SETTLE of col 5: colOut is all z at once, matrixOut=0, and the next scan starts at col 0.
